// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix bytes, default game key codes and parser state type.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_e;
endpackage

// File: rtl/ps2_byte_handshake.sv
// ps2_byte_handshake: synchronises scan_ready, accepts each ready level once and acknowledges it with read.
module ps2_byte_handshake (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scan_ready_i,
    input  logic [7:0] scan_code_i,
    output logic       read_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o
);
    logic [1:0] sync_q;
    logic       ack_wait_q, ack_wait_d, read_q;
    always_comb begin
        byte_valid_o = sync_q[1] & ~ack_wait_q;
        byte_data_o  = scan_code_i;
        // stay in ACK_WAIT until the receiver drops its ready level
        ack_wait_d   = byte_valid_o ? 1'b1 : ack_wait_q & sync_q[1];
        read_o       = read_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= '0;
            ack_wait_q <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], scan_ready_i};
            ack_wait_q <= ack_wait_d;
            read_q     <= byte_valid_o;
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: parses E0/F0 prefixed scan bytes into held state and one press pulse per key hit.
// Define PS2_AUTOREPEAT_EN to make typematic repeats of a held key pulse again.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter logic [7:0] CODE_B1        = KEY_RIGHT,
    parameter logic [7:0] CODE_B2        = KEY_DOWN,
    parameter logic [7:0] CODE_B3        = KEY_LEFT,
    parameter int         TIMEOUT_CYCLES = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    input  logic       game,
    output logic       read,
    output logic       button1,
    output logic       button2,
    output logic       button3,
    output logic [2:0] key_held,
    output logic       prefix_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic          byte_valid;
    logic [7:0]    byte_data;
    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    held_q, held_d, btn_q, btn_d, hit, press;
    logic          err_q, err_d, is_ext, is_brk, do_make, do_brk, timeout;

    ps2_byte_handshake u_hs (
        .clk_i        (CLOCK_50),
        .rst_i        (reset),
        .scan_ready_i (scan_ready),
        .scan_code_i  (scan_code),
        .read_o       (read),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data)
    );

    always_comb begin
        is_ext  = byte_data == PS2_EXT;
        is_brk  = byte_data == PS2_BRK;
        hit     = {byte_data == CODE_B3, byte_data == CODE_B2, byte_data == CODE_B1};
        do_brk  = byte_valid && (state_q == BRK || state_q == EXT_BRK);
        do_make = byte_valid && !do_brk && !is_ext && !is_brk;
        timeout = !byte_valid && state_q != IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_AUTOREPEAT_EN
        press   = hit;
`else
        press   = hit & ~held_q;
`endif
        state_d = byte_valid ? (do_brk ? IDLE : is_ext ? EXT : is_brk ? (state_q == EXT ? EXT_BRK : BRK) : IDLE)
                             : (timeout ? IDLE : state_q);
        cnt_d   = (byte_valid || timeout || state_q == IDLE) ? '0 : cnt_q + CW'(1);
        held_d  = do_make ? held_q | hit : do_brk ? held_q & ~hit : held_q;
        btn_d   = (do_make && game) ? press : 3'b000;
        err_d   = timeout;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
            btn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            btn_q   <= btn_d;
            err_q   <= err_d;
        end
    end

    assign {button3, button2, button1} = btn_q;
    assign key_held   = held_q;
    assign prefix_err = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized + directed scoreboard bench against a prefix/held-key reference model.
module tb_ps2_key_decoder;
    localparam int TO = 20;
    typedef struct packed {
        logic [2:0] btn;
        logic [2:0] held;
    } exp_t;

    logic       CLOCK_50 = 1'b0, reset = 1'b1, scan_ready = 1'b0, game = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       read, button1, button2, button3, prefix_err;
    logic [2:0] key_held;

    int   compared = 0, mismatched = 0, cyc = 0, last_read = 0;
    exp_t exp_q[$];
    int   err_q[$];
    bit   m_pending = 0;
    bit   m_brk = 0;
    bit   [2:0] m_held = '0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .game       (game),
        .read       (read),
        .button1    (button1),
        .button2    (button2),
        .button3    (button3),
        .key_held   (key_held),
        .prefix_err (prefix_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc++;

    function automatic int key_of(input logic [7:0] b);
        return b == 8'h74 ? 0 : b == 8'h72 ? 1 : b == 8'h6B ? 2 : -1;
    endfunction

    // reference model: a pending break releases the next code; otherwise prefixes are remembered
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        int   k;
        bit   autorep;
`ifdef PS2_AUTOREPEAT_EN
        autorep = 1;
`else
        autorep = 0;
`endif
        k = key_of(b);
        e.btn = '0;
        if (m_brk) begin
            if (k >= 0) m_held[k] = 1'b0;
            m_brk = 0;
            m_pending = 0;
        end else if (b == 8'hE0) begin
            m_pending = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
            m_pending = 1;
        end else begin
            if (k >= 0) begin
                if (game && (!m_held[k] || autorep)) e.btn[k] = 1'b1;
                m_held[k] = 1'b1;
            end
            m_pending = 0;
        end
        e.held = m_held;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int idle);
        int t = 0;
        model_byte(b);
        scan_code  = b;
        scan_ready = 1'b1;
        do begin
            @(negedge CLOCK_50);
            t++;
        end while (!read && t < 200);
        if (!read) check("read_timeout", 8'd0, 8'd1);
        repeat (hold) @(negedge CLOCK_50);
        scan_ready = 1'b0;
        repeat (idle) @(negedge CLOCK_50);
    endtask

    task automatic silence(input int n);
        if (m_pending) begin
            err_q.push_back(TO);
            m_pending = 0;
            m_brk = 0;
        end
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_outs", {read, button1, button2, button3, key_held, prefix_err}, 8'h00);
        repeat (3) @(negedge CLOCK_50);
        check("reset_held", {5'b0, key_held}, 8'h00);
        m_pending = 0;
        m_brk = 0;
        m_held = '0;
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    // monitor: every read pulse consumes one expected response
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (read) begin
                last_read = cyc;
                if (exp_q.size() == 0) check("unexpected_read", 8'd1, 8'd0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("buttons", {5'b0, button3, button2, button1}, {5'b0, e.btn});
                    check("key_held", {5'b0, key_held}, {5'b0, e.held});
                end
            end else if ({button3, button2, button1} != 3'b000) begin
                check("stray_pulse", {5'b0, button3, button2, button1}, 8'h00);
            end
            if (prefix_err) begin
                if (err_q.size() == 0) check("unexpected_prefix_err", 8'd1, 8'd0);
                else check("prefix_err_delay", 8'(cyc - last_read), 8'(err_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLOCK_50);
        do_reset();
        send(8'h74, 0, 3);
        send(8'hE0, 0, 2); send(8'h72, 0, 4);
        send(8'hE0, 0, 3); send(8'hF0, 0, 2); send(8'h72, 0, 5);
        send(8'h6B, 0, 2); send(8'h6B, 0, 3); send(8'h6B, 0, 2);
        send(8'hF0, 0, 4); send(8'h6B, 0, 3);
        send(8'hF0, 0, 2); send(8'h74, 0, 3);
        send(8'h74, 100, 4);
        send(8'hE0, 0, 2); silence(30);
        send(8'h74, 0, 3);
        send(8'hF0, 0, 2); silence(30);
        send(8'h74, 0, 3);
        game = 1'b0; send(8'h72, 0, 3);
        game = 1'b1; send(8'h72, 0, 3);
        send(8'hF0, 0, 3);
        do_reset();
        send(8'h72, 0, 3);
        for (int i = 0; i < 80; i++) begin
            int     r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = r < 2 ? 8'h74 : r < 4 ? 8'h72 : r < 6 ? 8'h6B : r == 6 ? 8'hE0 : r == 7 ? 8'hF0 : 8'($urandom_range(0, 255));
            game = $urandom_range(0, 3) != 0;
            send(b, $urandom_range(0, 3), $urandom_range(2, 6));
            if ($urandom_range(0, 15) == 0) silence(30);
        end
        silence(30);
        check("exp_q_drained", 8'(exp_q.size()), 8'd0);
        check("err_q_drained", 8'(err_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
